mul_seq_ctrl: RTL and testbench

- Multi-cycle sequencer that computes an N x N product by time-sharing one external (N/2) x (N/2) combinational multiplier (the team's shift-add array multiplier at width N/2).
- The block issues four half-width partial products (LL, LH, HL, HH), accumulates them into a 2N-bit result and signals completion.
- It sits between the CPU execute stage and the shared multiplier, replacing a full-width array with a quarter-size one.

---
 rtl/mul_seq_ctrl_if.sv | 39 +++
 rtl/mul_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_ctrl_if.sv
// Bus between the CPU execute stage, the multiply sequencer and the shared
// half-width multiplier. The signed-operand qualifier exists only when the
// MUL_SIGNED_EN macro is defined.
interface mul_seq_ctrl_if #(
  parameter int N = 16
);
  localparam int H = N / 2;

  logic           start;
  logic [N-1:0]   rs1_reg;
  logic [N-1:0]   rs2_reg;
  logic           busy;
  logic           done;
  logic [2*N-1:0] mul_rd;
  logic [H-1:0]   mul_a;
  logic [H-1:0]   mul_b;
  logic [2*H-1:0] mul_p;
`ifdef MUL_SIGNED_EN
  logic           is_signed;
`endif

  // Requester side: issues operands, observes status/result, returns mul_p
  modport master (
    output start, rs1_reg, rs2_reg, mul_p,
`ifdef MUL_SIGNED_EN
    output is_signed,
`endif
    input  busy, done, mul_rd, mul_a, mul_b
  );

  // Sequencer side
  modport slave (
    input  start, rs1_reg, rs2_reg, mul_p,
`ifdef MUL_SIGNED_EN
    input  is_signed,
`endif
    output busy, done, mul_rd, mul_a, mul_b
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: N x N multiply built from four passes through one shared
// (N/2) x (N/2) combinational multiplier (LL, LH, HL, HH), accumulated in
// 2N bits. Optional feature macro: MUL_SIGNED_EN adds an is_signed qualifier,
// magnitude conversion on entry and a FIX step that applies the sign.
module mul_seq_ctrl #(
  parameter int N = 16
) (
  input logic          clk,
  input logic          rst,
  mul_seq_ctrl_if.slave bus
);
  localparam int H = N / 2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LL   = 3'd1;
  localparam logic [2:0] S_LH   = 3'd2;
  localparam logic [2:0] S_HL   = 3'd3;
  localparam logic [2:0] S_HH   = 3'd4;
`ifdef MUL_SIGNED_EN
  localparam logic [2:0] S_FIX  = 3'd5;
`endif

  logic [2:0]     r_state;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [2*N-1:0] r_acc;
  logic [2*N-1:0] r_rd;
  logic           r_done;
`ifdef MUL_SIGNED_EN
  logic           r_signed_op;
  logic           r_neg;
`endif

  logic [N-1:0]   w_a_in;
  logic [N-1:0]   w_b_in;
  logic [H-1:0]   w_mul_a;
  logic [H-1:0]   w_mul_b;
  logic [2*N-1:0] w_p_ext;
  logic [2*N-1:0] w_term_mid;
  logic [2*N-1:0] w_term_hi;

  // Partial product zero-extended to 2N bits, plus its two shifted placements
  assign w_p_ext    = {{N{1'b0}}, bus.mul_p};
  assign w_term_mid = w_p_ext << H;
  assign w_term_hi  = w_p_ext << N;

  // Operand values captured on start; signed requests store magnitudes
  always_comb begin
    w_a_in = bus.rs1_reg;
    w_b_in = bus.rs2_reg;
`ifdef MUL_SIGNED_EN
    if (bus.is_signed && bus.rs1_reg[N-1]) begin
      w_a_in = ~bus.rs1_reg + {{(N-1){1'b0}}, 1'b1};
    end else begin
      w_a_in = bus.rs1_reg;
    end
    if (bus.is_signed && bus.rs2_reg[N-1]) begin
      w_b_in = ~bus.rs2_reg + {{(N-1){1'b0}}, 1'b1};
    end else begin
      w_b_in = bus.rs2_reg;
    end
`endif
  end

  // Select the operand halves presented to the shared multiplier
  always_comb begin
    w_mul_a = {H{1'b0}};
    w_mul_b = {H{1'b0}};
    case (r_state)
      S_LL: begin
        w_mul_a = r_a[H-1:0];
        w_mul_b = r_b[H-1:0];
      end
      S_LH: begin
        w_mul_a = r_a[H-1:0];
        w_mul_b = r_b[N-1:H];
      end
      S_HL: begin
        w_mul_a = r_a[N-1:H];
        w_mul_b = r_b[H-1:0];
      end
      S_HH: begin
        w_mul_a = r_a[N-1:H];
        w_mul_b = r_b[N-1:H];
      end
      default: begin
        w_mul_a = {H{1'b0}};
        w_mul_b = {H{1'b0}};
      end
    endcase
  end

  // Sequencer state, operand latches, accumulator and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= {N{1'b0}};
      r_b         <= {N{1'b0}};
      r_acc       <= {(2*N){1'b0}};
      r_rd        <= {(2*N){1'b0}};
      r_done      <= 1'b0;
`ifdef MUL_SIGNED_EN
      r_signed_op <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= w_a_in;
            r_b     <= w_b_in;
            r_acc   <= {(2*N){1'b0}};
            r_state <= S_LL;
`ifdef MUL_SIGNED_EN
            r_signed_op <= bus.is_signed;
            r_neg       <= bus.is_signed & (bus.rs1_reg[N-1] ^ bus.rs2_reg[N-1]);
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LL: begin
          r_acc   <= w_p_ext;
          r_state <= S_LH;
        end
        S_LH: begin
          r_acc   <= r_acc + w_term_mid;
          r_state <= S_HL;
        end
        S_HL: begin
          r_acc   <= r_acc + w_term_mid;
          r_state <= S_HH;
        end
        S_HH: begin
`ifdef MUL_SIGNED_EN
          if (r_signed_op) begin
            r_acc   <= r_acc + w_term_hi;
            r_state <= S_FIX;
          end else begin
            r_rd    <= r_acc + w_term_hi;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
`else
          r_rd    <= r_acc + w_term_hi;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
`endif
        end
`ifdef MUL_SIGNED_EN
        S_FIX: begin
          r_rd    <= r_neg ? (~r_acc + {{(2*N-1){1'b0}}, 1'b1}) : r_acc;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
`endif
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mul_a  = w_mul_a;
  assign bus.mul_b  = w_mul_b;
  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = r_done;
  assign bus.mul_rd = r_rd;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl (N=16). The shared half-width multiplier is
// modelled here as a plain combinational product. Signed tests are compiled
// only when MUL_SIGNED_EN is defined.
module tb_mul_seq_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mul_seq_ctrl_if #(.N(16)) bus ();

  mul_seq_ctrl #(.N(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.mul_p = 16'(bus.mul_a) * 16'(bus.mul_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Present operands and raise start at a falling edge, then take edge E0
  task automatic issue_start(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge clk);
    bus.rs1_reg = a;
    bus.rs2_reg = b;
`ifdef MUL_SIGNED_EN
    bus.is_signed = s;
`else
    if (s) begin
      $display("note: signed request ignored in unsigned build");
    end
`endif
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Called just after E0: count edges until done and cycles with busy high
  task automatic wait_done(output int lat, output int bcnt, output bit seen);
    lat  = 0;
    bcnt = 0;
    seen = 1'b0;
    @(negedge clk);
    if (bus.busy) bcnt++;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.rs1_reg = 16'h1111;
    bus.rs2_reg = 16'h2222;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.mul_rd !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h want 00000000", bus.mul_rd); end
    checks++; if ({bus.mul_a, bus.mul_b} !== 16'h0) begin errors++; $display("FAIL reset_mul_ab: got %h want 0000", {bus.mul_a, bus.mul_b}); end
    bus.start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat; int bcnt; bit seen;
    issue_start(16'h1234, 16'h5678, 1'b0);
    wait_done(lat, bcnt, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", seen); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
    checks++; if (bcnt !== 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 4", bcnt); end
    checks++; if (bus.mul_rd !== 32'h06260060) begin errors++; $display("FAIL basic_rd: got %h want 06260060", bus.mul_rd); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", bus.done); end
    checks++; if (bus.mul_rd !== 32'h06260060) begin errors++; $display("FAIL basic_rd_hold: got %h want 06260060", bus.mul_rd); end
  endtask

  task automatic test_max_zero;
    int lat; int bcnt; bit seen;
    issue_start(16'hFFFF, 16'hFFFF, 1'b0);
    wait_done(lat, bcnt, seen);
    checks++; if (seen !== 1'b1 || lat !== 4) begin errors++; $display("FAIL max_latency: got seen=%b lat=%0d want 1/4", seen, lat); end
    checks++; if (bus.mul_rd !== 32'hFFFE0001) begin errors++; $display("FAIL max_rd: got %h want fffe0001", bus.mul_rd); end
    issue_start(16'h0000, 16'hABCD, 1'b0);
    wait_done(lat, bcnt, seen);
    checks++; if (seen !== 1'b1 || lat !== 4) begin errors++; $display("FAIL zero_latency: got seen=%b lat=%0d want 1/4", seen, lat); end
    checks++; if (bus.mul_rd !== 32'h00000000) begin errors++; $display("FAIL zero_rd: got %h want 00000000", bus.mul_rd); end
  endtask

  task automatic test_back_to_back;
    int lat; int bcnt; bit seen;
    @(negedge clk);
    bus.rs1_reg = 16'd3;
    bus.rs2_reg = 16'd5;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    // start stays high; new operands while busy must not be captured
    bus.rs1_reg = 16'd7;
    bus.rs2_reg = 16'd9;
    wait_done(lat, bcnt, seen);
    checks++; if (seen !== 1'b1 || lat !== 4) begin errors++; $display("FAIL b2b_first_latency: got seen=%b lat=%0d want 1/4", seen, lat); end
    checks++; if (bus.mul_rd !== 32'h0000000F) begin errors++; $display("FAIL b2b_first_rd: got %h want 0000000f", bus.mul_rd); end
    // start held high in the done cycle is accepted at the next edge
    @(posedge clk);
    #1;
    wait_done(lat, bcnt, seen);
    bus.start = 1'b0;
    checks++; if (seen !== 1'b1 || lat !== 4) begin errors++; $display("FAIL b2b_second_latency: got seen=%b lat=%0d want 1/4", seen, lat); end
    checks++; if (bus.mul_rd !== 32'h0000003F) begin errors++; $display("FAIL b2b_second_rd: got %h want 0000003f", bus.mul_rd); end
  endtask

  task automatic test_reset_mid;
    int lat; int bcnt; bit seen;
    issue_start(16'h1234, 16'h5678, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.mul_a !== 8'h12 || bus.mul_b !== 8'h78) begin errors++; $display("FAIL mid_hl_operands: got %h/%h want 12/78", bus.mul_a, bus.mul_b); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL mid_rst_status: got busy=%b done=%b want 0/0", bus.busy, bus.done); end
    checks++; if (bus.mul_rd !== 32'h0) begin errors++; $display("FAIL mid_rst_rd: got %h want 00000000", bus.mul_rd); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_rst_discard: got done=%b want 0", seen); end
    issue_start(16'd2, 16'd2, 1'b0);
    wait_done(lat, bcnt, seen);
    checks++; if (seen !== 1'b1 || bus.mul_rd !== 32'h00000004) begin errors++; $display("FAIL mid_rst_after: got seen=%b rd=%h want 1/00000004", seen, bus.mul_rd); end
  endtask

  task automatic test_input_stability;
    int lat; bit seen;
    issue_start(16'h0100, 16'h0100, 1'b0);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.rs1_reg = 16'($urandom);
      bus.rs2_reg = 16'($urandom);
      @(posedge clk);
      lat++;
      #1;
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (seen !== 1'b1 || lat !== 4) begin errors++; $display("FAIL stable_latency: got seen=%b lat=%0d want 1/4", seen, lat); end
    checks++; if (bus.mul_rd !== 32'h00010000) begin errors++; $display("FAIL stable_rd: got %h want 00010000", bus.mul_rd); end
  endtask

`ifdef MUL_SIGNED_EN
  task automatic test_signed;
    int lat; int bcnt; bit seen;
    issue_start(16'hFFFE, 16'h0003, 1'b1);
    wait_done(lat, bcnt, seen);
    checks++; if (seen !== 1'b1 || lat !== 5) begin errors++; $display("FAIL signed_latency: got seen=%b lat=%0d want 1/5", seen, lat); end
    checks++; if (bcnt !== 5) begin errors++; $display("FAIL signed_busy_cycles: got %0d want 5", bcnt); end
    checks++; if (bus.mul_rd !== 32'hFFFFFFFA) begin errors++; $display("FAIL signed_rd: got %h want fffffffa", bus.mul_rd); end
    issue_start(16'hFFFE, 16'h0003, 1'b0);
    wait_done(lat, bcnt, seen);
    checks++; if (seen !== 1'b1 || lat !== 4) begin errors++; $display("FAIL unsigned_mode_latency: got seen=%b lat=%0d want 1/4", seen, lat); end
    checks++; if (bus.mul_rd !== 32'h0002FFFA) begin errors++; $display("FAIL unsigned_mode_rd: got %h want 0002fffa", bus.mul_rd); end
    issue_start(16'h8000, 16'h8000, 1'b1);
    wait_done(lat, bcnt, seen);
    checks++; if (seen !== 1'b1 || bus.mul_rd !== 32'h40000000) begin errors++; $display("FAIL signed_min_rd: got seen=%b rd=%h want 1/40000000", seen, bus.mul_rd); end
    bus.is_signed = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.rs1_reg = 16'h0;
    bus.rs2_reg = 16'h0;
`ifdef MUL_SIGNED_EN
    bus.is_signed = 1'b0;
`endif
    test_reset();
    test_basic();
    test_max_zero();
    test_back_to_back();
    test_reset_mid();
    test_input_stability();
`ifdef MUL_SIGNED_EN
    test_signed();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
